// File: rtl/sub_div_sequencer.sv
// Sequential restoring divider: one quotient bit per clock, built around a
// single (size+1)-bit subtractor. Zero divisors short-circuit to a saturated
// result. Results are registered and held until the next completion.

// Generic N-bit subtractor; o_neg is the borrow out, i.e. a < b (unsigned).
module sub_nbit #(
   parameter int N = 5
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic [N-1:0] o_diff,
   output logic         o_neg
);
   assign {o_neg, o_diff} = {1'b0, i_a} - {1'b0, i_b};
endmodule

module sub_div_sequencer #(
   parameter int size = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [size-1:0] in_a,
   input  logic [size-1:0] in_b,
   output logic            busy,
   output logic            done,
   output logic [size-1:0] quotient,
   output logic [size-1:0] remainder,
   output logic            div_by_zero
);
   localparam int CW = $clog2(size + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          r_state;
   logic [size-1:0] r_q;      // dividend shifting out, quotient shifting in
   logic [size-1:0] r_b;      // latched divisor
   logic [size:0]   r_r;      // partial remainder
   logic [CW-1:0]   r_cnt;    // steps still to perform
   logic            r_busy;
   logic            r_done;
   logic [size-1:0] r_quot;
   logic [size-1:0] r_rem;
   logic            r_dbz;

   logic [size:0]   w_p;
   logic [size:0]   w_d;
   logic            w_neg;
   logic [size:0]   w_r_nxt;
   logic [size-1:0] w_q_nxt;
   logic            w_accept;

   // Shift the next dividend bit into the partial remainder.
   always_comb begin
      w_p    = r_r << 1;
      w_p[0] = r_q[size-1];
   end

   sub_nbit #(.N(size + 1)) u_sub (
      .i_a    (w_p),
      .i_b    ({1'b0, r_b}),
      .o_diff (w_d),
      .o_neg  (w_neg)
   );

   // Restore on borrow; the quotient bit is the inverted borrow.
   always_comb begin
      w_r_nxt    = w_neg ? w_p : w_d;
      w_q_nxt    = r_q << 1;
      w_q_nxt[0] = ~w_neg;
   end

   // A new request can be taken whenever no division is iterating.
   assign w_accept = start && (r_state != RUN);

   // Control FSM plus datapath and registered results.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_q     <= '0;
         r_b     <= '0;
         r_r     <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_quot  <= '0;
         r_rem   <= '0;
         r_dbz   <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               r_r   <= w_r_nxt;
               r_q   <= w_q_nxt;
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CW'(1)) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_quot  <= w_q_nxt;
                  // Remainder is always < divisor, so the top bit is zero.
                  r_rem   <= w_r_nxt[size-1:0];
                  r_dbz   <= 1'b0;
               end
            end
            default: begin
               // IDLE and DONE behave alike: DONE only differs in done=1.
               r_done <= 1'b0;
               if (w_accept) begin
                  if (in_b == '0) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                     r_quot  <= '1;
                     r_rem   <= in_a;
                     r_dbz   <= 1'b1;
                  end else begin
                     r_state <= RUN;
                     r_busy  <= 1'b1;
                     r_q     <= in_a;
                     r_b     <= in_b;
                     r_r     <= '0;
                     r_cnt   <= CW'(size);
                  end
               end else begin
                  r_state <= IDLE;
               end
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign quotient    = r_quot;
   assign remainder   = r_rem;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_sub_div_sequencer.sv
// Bench for sub_div_sequencer: an arithmetic reference model checked every
// cycle, plus directed operations with hand-computed results and latencies.
module tb_sub_div_sequencer;
   localparam int SIZE = 4;

   logic            clk = 1'b0;
   logic            reset_n = 1'b1;
   logic            start = 1'b0;
   logic [SIZE-1:0] in_a = '0;
   logic [SIZE-1:0] in_b = '0;
   logic            busy, done, div_by_zero;
   logic [SIZE-1:0] quotient, remainder;

   int errors = 0;
   int checks = 0;

   sub_div_sequencer #(.size(SIZE)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .in_a        (in_a),
      .in_b        (in_b),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: remaining busy cycles plus results from / and %.
   int            m_run = 0;
   logic          m_done = 1'b0;
   logic [SIZE-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
   logic          m_dbz = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_run  <= 0;
         m_done <= 1'b0;
         m_q    <= '0;
         m_r    <= '0;
         m_dbz  <= 1'b0;
      end else if (m_run > 0) begin
         m_run <= m_run - 1;
         if (m_run == 1) begin
            m_done <= 1'b1;
            m_q    <= p_q;
            m_r    <= p_r;
            m_dbz  <= 1'b0;
         end else begin
            m_done <= 1'b0;
         end
      end else begin
         m_done <= 1'b0;
         if (start) begin
            if (in_b == 0) begin
               m_done <= 1'b1;
               m_q    <= '1;
               m_r    <= in_a;
               m_dbz  <= 1'b1;
            end else begin
               m_run <= SIZE;
               p_q   <= in_a / in_b;
               p_r   <= in_a % in_b;
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      chk("busy", int'(busy), int'(m_run > 0));
      chk("done", int'(done), int'(m_done));
      chk("quotient", int'(quotient), int'(m_q));
      chk("remainder", int'(remainder), int'(m_r));
      chk("div_by_zero", int'(div_by_zero), int'(m_dbz));
   end

   // Issue one operation, optionally poke start mid-run, and pin the result.
   task automatic run_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                         input int eq, input int er, input int ez,
                         input int elat, input bit poke, input string tag);
      int lat;
      lat = 0;
      @(negedge clk);
      start = 1'b1; in_a = a; in_b = b;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0;
            in_a  = SIZE'($urandom);
            in_b  = SIZE'($urandom);
         end
         if (poke && k == 2) begin
            start = 1'b1; in_a = 4'd9; in_b = 4'd2;
         end
         if (poke && k == 3) start = 1'b0;
         if (done) begin
            lat = k;
            break;
         end
      end
      start = 1'b0;
      chk({tag, " latency"}, lat, elat);
      chk({tag, " quotient"}, int'(quotient), eq);
      chk({tag, " remainder"}, int'(remainder), er);
      chk({tag, " dbz"}, int'(div_by_zero), ez);
   endtask

   initial begin
      int lat;
      #1 reset_n = 1'b0;
      @(negedge clk);
      chk("rst busy", int'(busy), 0);
      chk("rst done", int'(done), 0);
      chk("rst quotient", int'(quotient), 0);
      chk("rst remainder", int'(remainder), 0);
      chk("rst dbz", int'(div_by_zero), 0);
      @(negedge clk);
      reset_n = 1'b1;

      // First start straight after reset release.
      run_op(4'd13, 4'd3, 4, 1, 0, 5, 1'b0, "13/3");
      run_op(4'd15, 4'd1, 15, 0, 0, 5, 1'b0, "15/1");
      run_op(4'd3, 4'd9, 0, 3, 0, 5, 1'b0, "3/9");
      run_op(4'd7, 4'd0, 15, 7, 1, 1, 1'b0, "7/0");
      run_op(4'd8, 4'd2, 4, 0, 0, 5, 1'b0, "8/2");
      run_op(4'd0, 4'd5, 0, 0, 0, 5, 1'b0, "0/5");
      run_op(4'd15, 4'd15, 1, 0, 0, 5, 1'b0, "15/15");
      run_op(4'd14, 4'd4, 3, 2, 0, 5, 1'b0, "14/4");
      run_op(4'd1, 4'd15, 0, 1, 0, 5, 1'b0, "1/15");
      run_op(4'd0, 4'd0, 15, 0, 1, 1, 1'b0, "0/0");
      // start re-pulsed during RUN must not disturb the running division.
      run_op(4'd13, 4'd3, 4, 1, 0, 5, 1'b1, "poke 13/3");

      // start held through DONE: back-to-back with no idle cycle.
      @(negedge clk);
      start = 1'b1; in_a = 4'd13; in_b = 4'd3;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) begin in_a = 4'd10; in_b = 4'd3; end
         if (done) begin lat = k; break; end
      end
      chk("held first latency", lat, 5);
      chk("held first quotient", int'(quotient), 4);
      @(negedge clk);
      chk("held busy after done", int'(busy), 1);
      start = 1'b0;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (done) begin lat = k; break; end
      end
      chk("held second latency", lat, 4);
      chk("held second quotient", int'(quotient), 3);
      chk("held second remainder", int'(remainder), 1);

      // Asynchronous reset two cycles into a 13/3 operation.
      @(negedge clk);
      start = 1'b1; in_a = 4'd13; in_b = 4'd3;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("async busy", int'(busy), 0);
      chk("async done", int'(done), 0);
      chk("async quotient", int'(quotient), 0);
      chk("async remainder", int'(remainder), 0);
      chk("async dbz", int'(div_by_zero), 0);
      repeat (6) @(negedge clk);
      reset_n = 1'b1;
      run_op(4'd13, 4'd3, 4, 1, 0, 5, 1'b0, "13/3 after reset");

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sub_div_sequencer.md
SUB_DIV_SEQUENCER -- requirements
Module: sub_div_sequencer

Interface
REQ-001 SHALL have parameter size, default 4, setting the operand, quotient and remainder width in bits.
REQ-002 SHALL have port clk, input, 1 bit, single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit, request to begin a division; sampled at the rising edge of clk.
REQ-005 SHALL have port in_a, input, size bits, unsigned dividend; sampled only when start is accepted.
REQ-006 SHALL have port in_b, input, size bits, unsigned divisor; sampled only when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit, high while a division is iterating.
REQ-008 SHALL have port done, output, 1 bit, high for exactly one cycle when the result becomes valid.
REQ-009 SHALL have port quotient, output, size bits, result of in_a / in_b.
REQ-010 SHALL have port remainder, output, size bits, result of in_a mod in_b.
REQ-011 SHALL have port div_by_zero, output, 1 bit, high when the last accepted divisor was 0.

Function
REQ-012 SHALL implement a state machine with three states: IDLE, RUN and DONE.
REQ-013 SHALL accept start only in IDLE or DONE, which allows back-to-back operations; start SHALL be ignored in RUN.
REQ-014 On acceptance with in_b != 0: latch in_a into the quotient shift register, latch in_b, clear the partial remainder (size+1 bits), load the iteration counter with size, and go to RUN.
REQ-015 On acceptance with in_b == 0: go to DONE on the next edge with quotient = all ones, remainder = in_a and div_by_zero = 1, with no RUN cycles.
REQ-016 Each RUN cycle SHALL perform one restoring step, so all size steps complete in size cycles:
  - shift: P = {R[size-1:0], Q[size-1]};
  - compute D = P - {1'b0, B};
  - if there is no borrow: R = D and shift 1 into the Q LSB;
  - otherwise: R = P and shift 0 into the Q LSB.
REQ-017 Each step SHALL use exactly one instance of the team's N-bit subtractor at width size+1; the no-borrow decision is taken from that subtractor's negative output being 0.
REQ-018 RUN SHALL decrement the counter each cycle and transition to DONE after the size-th step.
REQ-019 done SHALL be 1 only in DONE; DONE SHALL last one cycle and then go to IDLE, unless start is accepted, in which case it goes to RUN (or back to DONE for a zero divisor).
REQ-020 busy SHALL be 1 exactly when state = RUN.
REQ-021 Latency SHALL be fixed: done is asserted size+1 edges after the accepting edge for a nonzero divisor, and 1 edge after it for a zero divisor.
REQ-022 quotient, remainder and div_by_zero SHALL be registered, updated only on the edge entering DONE, and held unchanged until the next DONE.
REQ-023 div_by_zero SHALL be cleared on the edge entering DONE for any nonzero-divisor operation.
REQ-024 in_a and in_b SHALL be ignored outside the acceptance edge; changing them during RUN SHALL NOT affect the result.
REQ-025 Results SHALL satisfy quotient*in_b + remainder = in_a and remainder < in_b for every nonzero in_b, including in_a < in_b (quotient 0) and in_a = 0.

Reset
REQ-026 While reset_n = 0: state = IDLE, busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0, counter and internal registers = 0, independent of clk.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the operation immediately with no done pulse.
REQ-028 The first start SHALL be accepted on the first rising edge after reset_n returns high.

Verification (size = 4)
REQ-029 start with in_a=13, in_b=3 -> busy high for 4 cycles, done pulse on the 5th edge, quotient=4, remainder=1, div_by_zero=0.
REQ-030 in_a=15, in_b=1 -> quotient=15, remainder=0; then in_a=3, in_b=9 -> quotient=0, remainder=3.
REQ-031 in_a=7, in_b=0 -> done on the next edge, quotient=15, remainder=7, div_by_zero=1, busy never high; a following 8/2 gives quotient=4, remainder=0, div_by_zero=0.
REQ-032 start pulsed again during RUN with different operands -> ignored; the original result is produced at the original latency.
REQ-033 start held high through DONE -> a new operation starts immediately, with no IDLE cycle between the done pulse and busy rising.
REQ-034 reset_n driven low 2 cycles into a 13/3 operation -> all outputs 0 asynchronously, no done pulse, and a correct 13/3 result when the operation is restarted after release.
